// File: rtl/lockin_cfg_pkg.sv
// lockin_cfg_pkg
// Shared constants and types for the lock-in GPIO configuration hub:
// register index map, readback select bases, CTRL field offsets and the
// per-channel register record with its word-select helper.
// Optional feature macro used by consumers: CFG_READBACK_EN (shadow readback).
package lockin_cfg_pkg;

  // Register indices (reg = addr[15:2])
  localparam int REG_LED    = 0;
  localparam int REG_COMMIT = 1;
  localparam int REG_RDSEL  = 2;
  localparam int REG_ID     = 3;
  localparam int CH_BASE    = 4;
  localparam int CH_STRIDE  = 4;

  // Offsets inside one channel's register group
  localparam int CH_INC   = 0;
  localparam int CH_SCALE = 1;
  localparam int CH_CTRL  = 2;

  // Readback select values / bases
  localparam logic [7:0] SEL_ID  = 8'h00;
  localparam logic [7:0] SEL_CNT = 8'h01;
  localparam logic [7:0] SEL_RES = 8'h10;
  localparam logic [7:0] SEL_ACT = 8'h40;
  localparam logic [7:0] SEL_SHD = 8'h80;

  // CTRL register bit positions
  localparam int CTRL_SINC_BIT  = 0;
  localparam int CTRL_UCNTR_BIT = 1;

  typedef struct packed {
    logic [31:0] inc;
    logic [3:0]  scale;
    logic [1:0]  ctrl;
  } ch_regs_t;

  // Register k of a channel as a 32-bit readback word (k = 3 is reserved).
  function automatic logic [31:0] ch_word(input ch_regs_t r, input logic [1:0] k);
    case (k)
      2'd0:    return r.inc;
      2'd1:    return {28'h0, r.scale};
      2'd2:    return {30'h0, r.ctrl};
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/gpio_strobe_sync.sv
// gpio_strobe_sync
// Brings the asynchronous GPIO write strobe into the clk domain (2-FF
// synchroniser), detects its rising edge and captures address/data on the
// edge-detect cycle. Produces a one-cycle write request.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   gpio_i [31:0]  raw GPIO bus: [ADDR_W-1:0] addr, [23:16] data, [W_CLK_BIT] strobe
//   wr_o           one-cycle write request
//   addr_o, data_o captured address / data byte, valid while wr_o is high
module gpio_strobe_sync #(
  parameter int ADDR_W    = 16,
  parameter int W_CLK_BIT = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       gpio_i,
  output logic              wr_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [7:0]        data_o
);

  logic              sync1_q, sync2_q, prev_q;
  logic [1:0]        warm_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        data_q;
  logic              edge_d;
  logic              unused_gpio;

  assign unused_gpio = ^gpio_i;

  // warm_q counts clocks since reset release; prev_q only holds a genuine
  // sample once it reaches 3, so a strobe already high at release is not
  // mistaken for a rising edge.
  assign edge_d = sync2_q & ~prev_q & (warm_q == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      warm_q  <= 2'd0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      sync1_q <= gpio_i[W_CLK_BIT];
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (warm_q != 2'd3) warm_q <= warm_q + 2'd1;
      wr_q <= edge_d;
      if (edge_d) begin
        addr_q <= gpio_i[ADDR_W-1:0];
        data_q <= gpio_i[23:16];
      end
    end
  end

  assign wr_o   = wr_q;
  assign addr_o = addr_q;
  assign data_o = data_q;

endmodule

// File: rtl/lockin_cfg_hub.sv
// lockin_cfg_hub
// GPIO-bus register file for N_CH lock-in channels: byte-lane writes into a
// shadow copy, atomic shadow->active commit, direct LED register and a
// registered readback mux (ID, write counter, channel results, active regs).
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   gpio_in [31:0]             PS GPIO write bus (addr, data byte, w_clk strobe)
//   res_x/res_y/res_sin/res_cos per-channel DW-bit results, channel c at [c*DW +: DW]
//   inc_out, scale_out, sinc_out, ucntr_out  active per-channel configuration
//   led_out                    LED register
//   commit_pulse               high during the cycle shadow is copied to active
//   gpio_out                   registered readback word
// Optional: define CFG_READBACK_EN to expose shadow regs at RDSEL 0x80+4c+k.
module lockin_cfg_hub
  import lockin_cfg_pkg::*;
#(
  parameter int          N_CH      = 2,
  parameter int          DW        = 16,
  parameter int          ADDR_W    = 16,
  parameter int          W_CLK_BIT = 24,
  parameter logic [31:0] ID_VALUE  = 32'h4C4B0002
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          gpio_in,
  input  logic [N_CH*DW-1:0]   res_x,
  input  logic [N_CH*DW-1:0]   res_y,
  input  logic [N_CH*DW-1:0]   res_sin,
  input  logic [N_CH*DW-1:0]   res_cos,
  output logic [N_CH*32-1:0]   inc_out,
  output logic [N_CH*4-1:0]    scale_out,
  output logic [N_CH-1:0]      sinc_out,
  output logic [N_CH-1:0]      ucntr_out,
  output logic [7:0]           led_out,
  output logic                 commit_pulse,
  output logic [31:0]          gpio_out
);

  localparam int RW = ADDR_W - 2;

  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        data;
  logic [RW-1:0]     reg_idx;
  logic [1:0]        lane;

  logic [7:0]  led_q, sel_q;
  logic [15:0] cnt_q;
  logic        commit_q;
  logic [31:0] gpio_out_q, rd_d;

  ch_regs_t act_a [N_CH];
`ifdef CFG_READBACK_EN
  ch_regs_t shd_a [N_CH];
`endif

  gpio_strobe_sync #(.ADDR_W(ADDR_W), .W_CLK_BIT(W_CLK_BIT)) u_strobe (
    .clk    (clk),
    .rst_n  (rst),
    .gpio_i (gpio_in),
    .wr_o   (wr),
    .addr_o (addr),
    .data_o (data)
  );

  assign reg_idx = addr[ADDR_W-1:2];
  assign lane    = addr[1:0];

  // Global registers; every strobe edge counts as an accepted write,
  // including those that land on ignored addresses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_q      <= '0;
      sel_q      <= '0;
      cnt_q      <= '0;
      commit_q   <= 1'b0;
      gpio_out_q <= '0;
    end else begin
      commit_q   <= 1'b0;
      gpio_out_q <= rd_d;
      if (wr) begin
        cnt_q <= cnt_q + 16'd1;
        if (reg_idx == RW'(REG_LED) && lane == 2'd0)   led_q <= data;
        if (reg_idx == RW'(REG_RDSEL) && lane == 2'd0) sel_q <= data;
        if (reg_idx == RW'(REG_COMMIT))                commit_q <= 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      localparam int BASE = CH_BASE + CH_STRIDE * gi;
      ch_regs_t shd_q, act_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          shd_q <= '0;
          act_q <= '0;
        end else begin
          if (wr && reg_idx == RW'(BASE + CH_INC))
            shd_q.inc[{lane, 3'b000} +: 8] <= data;
          if (wr && reg_idx == RW'(BASE + CH_SCALE) && lane == 2'd0)
            shd_q.scale <= data[3:0];
          if (wr && reg_idx == RW'(BASE + CH_CTRL) && lane == 2'd0)
            shd_q.ctrl <= data[1:0];
          if (commit_q)
            act_q <= shd_q;
        end
      end

      assign act_a[gi] = act_q;
`ifdef CFG_READBACK_EN
      assign shd_a[gi] = shd_q;
`endif
      assign inc_out[gi*32 +: 32] = act_q.inc;
      assign scale_out[gi*4 +: 4] = act_q.scale;
      assign sinc_out[gi]         = act_q.ctrl[CTRL_SINC_BIT];
      assign ucntr_out[gi]        = act_q.ctrl[CTRL_UCNTR_BIT];
    end
  endgenerate

  // Readback source select; unmatched selects read as 0.
  always_comb begin
    logic [DW-1:0] rw;
    rw   = '0;
    rd_d = '0;
    if (sel_q == SEL_ID)  rd_d = ID_VALUE;
    if (sel_q == SEL_CNT) rd_d = {16'h0, cnt_q};
    for (int c = 0; c < N_CH; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (sel_q == 8'(int'(SEL_RES) + 4 * c + k)) begin
          case (k)
            0:       rw = res_x[c*DW +: DW];
            1:       rw = res_y[c*DW +: DW];
            2:       rw = res_sin[c*DW +: DW];
            default: rw = res_cos[c*DW +: DW];
          endcase
          rd_d = 32'($signed(rw));
        end
        if (sel_q == 8'(int'(SEL_ACT) + 4 * c + k))
          rd_d = ch_word(act_a[c], 2'(k));
`ifdef CFG_READBACK_EN
        if (sel_q == 8'(int'(SEL_SHD) + 4 * c + k))
          rd_d = ch_word(shd_a[c], 2'(k));
`endif
      end
    end
  end

  assign led_out      = led_q;
  assign commit_pulse = commit_q;
  assign gpio_out     = gpio_out_q;

endmodule

// File: tb/tb_lockin_cfg_hub.sv
// Self-checking bench for lockin_cfg_hub (N_CH = 2, DW = 16).
// Readback vectors come from a table; register writes, commit timing,
// strobe hold and reset corner cases are hand-written sequences.
module tb_lockin_cfg_hub;

  localparam int N_CH = 2;
  localparam int DW   = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic [31:0]         gpio_in;
  logic [N_CH*DW-1:0]  res_x, res_y, res_sin, res_cos;
  logic [N_CH*32-1:0]  inc_out;
  logic [N_CH*4-1:0]   scale_out;
  logic [N_CH-1:0]     sinc_out, ucntr_out;
  logic [7:0]          led_out;
  logic                commit_pulse;
  logic [31:0]         gpio_out;

  always #5 clk = ~clk;

  lockin_cfg_hub #(.N_CH(N_CH), .DW(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .gpio_in      (gpio_in),
    .res_x        (res_x),
    .res_y        (res_y),
    .res_sin      (res_sin),
    .res_cos      (res_cos),
    .inc_out      (inc_out),
    .scale_out    (scale_out),
    .sinc_out     (sinc_out),
    .ucntr_out    (ucntr_out),
    .led_out      (led_out),
    .commit_pulse (commit_pulse),
    .gpio_out     (gpio_out)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int exp_cnt = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  typedef struct {
    logic [7:0]  sel;
    logic [31:0] x, y, s, c;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // One GPIO write: set addr/data, raise strobe for 'hold' cycles, drop it.
  task automatic gpio_write(input logic [15:0] a, input logic [7:0] d, input int hold);
    @(negedge clk);
    gpio_in = {7'b0, 1'b0, d, a};
    repeat (2) @(negedge clk);
    gpio_in[24] = 1'b1;
    repeat (hold) @(negedge clk);
    gpio_in[24] = 1'b0;
    repeat (6) @(negedge clk);
    exp_cnt++;
  endtask

  // Select a readback source, push the expected word, then pop and compare.
  task automatic rd_expect(input string nm, input logic [7:0] sel, input logic [31:0] exp);
    gpio_write(16'h0008, sel, 4);
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(negedge clk);
    chk(name_q.pop_front(), {32'h0, gpio_out}, {32'h0, exp_q.pop_front()});
    $display("read sel=0x%02h gpio_out=0x%08h", sel, gpio_out);
  endtask

  // Write COMMIT and check the one-cycle pulse.
  task automatic do_commit(input string nm);
    int n;
    @(negedge clk);
    gpio_in = 32'h0000_0004;
    repeat (2) @(negedge clk);
    gpio_in[24] = 1'b1;
    n = 0;
    while (commit_pulse !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_pulse_seen"}, {63'h0, commit_pulse}, 64'h1);
    @(negedge clk);
    chk({nm, "_pulse_one_cycle"}, {63'h0, commit_pulse}, 64'h0);
    gpio_in[24] = 1'b0;
    repeat (6) @(negedge clk);
    exp_cnt++;
    $display("commit %s done", nm);
  endtask

  initial begin
    int n;

    // sel, x, y, sin, cos ({ch1,ch0}), expected readback
    vecs[0]  = '{8'h11, 32'h0, 32'h0000_8001, 32'h0, 32'h0, 32'hFFFF_8001};
    vecs[1]  = '{8'h10, 32'h0000_1234, 32'h0, 32'h0, 32'h0, 32'h0000_1234};
    vecs[2]  = '{8'h17, 32'h0, 32'h0, 32'h0, 32'hFFFF_0000, 32'hFFFF_FFFF};
    vecs[3]  = '{8'h16, 32'h0, 32'h0, 32'h7FFF_0000, 32'h0, 32'h0000_7FFF};
    vecs[4]  = '{8'h13, 32'h0, 32'h0, 32'h0, 32'h0000_8000, 32'hFFFF_8000};
    vecs[5]  = '{8'h15, 32'h0, 32'hABCD_0000, 32'h0, 32'h0, 32'hFFFF_ABCD};
    vecs[6]  = '{8'h18, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[7]  = '{8'h05, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[8]  = '{8'h00, 32'h0, 32'h0, 32'h0, 32'h0, 32'h4C4B_0002};
    vecs[9]  = '{8'h44, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1234_5678};
    vecs[10] = '{8'h47, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[11] = '{8'h41, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
`ifdef CFG_READBACK_EN
    vecs[12] = '{8'h84, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1234_5678};
`else
    vecs[12] = '{8'h84, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
`endif

    rst = 1'b0;
    gpio_in = '0;
    res_x = '0; res_y = '0; res_sin = '0; res_cos = '0;
    repeat (3) @(negedge clk);
    chk("rst_gpio_out", {32'h0, gpio_out}, 64'h0);
    chk("rst_inc_out", inc_out, 64'h0);
    chk("rst_led_out", {56'h0, led_out}, 64'h0);
    chk("rst_commit_pulse", {63'h0, commit_pulse}, 64'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("id_after_reset", {32'h0, gpio_out}, 64'h4C4B_0002);
    chk("rst_scale_ctrl", {52'h0, scale_out, sinc_out, ucntr_out}, 64'h0);

    // LED: direct effect, within 4 clk of the strobe edge
    @(negedge clk);
    gpio_in = {8'h00, 8'hA5, 16'h0000};
    repeat (2) @(negedge clk);
    gpio_in[24] = 1'b1;
    n = 0;
    while (led_out !== 8'hA5 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("led_value", {56'h0, led_out}, 64'hA5);
    chk("led_within_4clk", {63'h0, (n <= 4)}, 64'h1);
    $display("led write took %0d clk", n);
    gpio_in[24] = 1'b0;
    repeat (6) @(negedge clk);
    exp_cnt++;

    // ch1 INC staged as four lane writes, then committed
    gpio_write(16'h0020, 8'h78, 6);
    gpio_write(16'h0021, 8'h56, 6);
    gpio_write(16'h0022, 8'h34, 6);
    gpio_write(16'h0023, 8'h12, 6);
    chk("inc_ch1_before_commit", {32'h0, inc_out[63:32]}, 64'h0);
    @(negedge clk);
    gpio_in = 32'h0000_0004;
    repeat (2) @(negedge clk);
    gpio_in[24] = 1'b1;
    n = 0;
    while (commit_pulse !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("commit_pulse_seen", {63'h0, commit_pulse}, 64'h1);
    chk("inc_unchanged_in_commit_cycle", inc_out, 64'h0);
    @(negedge clk);
    chk("commit_pulse_one_cycle", {63'h0, commit_pulse}, 64'h0);
    chk("inc_after_commit", inc_out, 64'h1234_5678_0000_0000);
    gpio_in[24] = 1'b0;
    repeat (6) @(negedge clk);
    exp_cnt++;

    // Table-driven readback
    for (int i = 0; i < 13; i++) begin
      res_x = vecs[i].x; res_y = vecs[i].y; res_sin = vecs[i].s; res_cos = vecs[i].c;
      rd_expect($sformatf("rdsel_vec%0d", i), vecs[i].sel, vecs[i].exp);
    end

    // One-cycle latency from a result change
    res_x = 32'h0000_0007;
    rd_expect("lat_setup", 8'h10, 32'h0000_0007);
    @(negedge clk);
    res_x = 32'h0000_0042;
    #1;
    chk("lat_not_yet", {32'h0, gpio_out}, 64'h7);
    @(posedge clk);
    #1;
    chk("lat_one_cycle", {32'h0, gpio_out}, 64'h42);

    // Write counter: strobe held 50 cycles counts once; ignored regs still count
    gpio_write(16'h0008, 8'h01, 4);
    chk("cnt_initial", {32'h0, gpio_out}, 64'(exp_cnt));
    gpio_write(16'h001C, 8'hFF, 50);
    chk("cnt_long_strobe_reserved", {32'h0, gpio_out}, 64'(exp_cnt));
    gpio_write(16'h000C, 8'hFF, 6);
    chk("cnt_id_write", {32'h0, gpio_out}, 64'(exp_cnt));
    do_commit("commit2");
    chk("cnt_after_commit", {32'h0, gpio_out}, 64'(exp_cnt));
    chk("inc_unaffected_by_ignored", inc_out, 64'h1234_5678_0000_0000);
    chk("scale_unaffected_by_ignored", {56'h0, scale_out}, 64'h0);
    chk("led_unaffected_by_ignored", {56'h0, led_out}, 64'hA5);

    // Stage ch0 SCALE and CTRL, check shadow vs active readback, commit
    gpio_write(16'h0014, 8'h09, 6);
`ifdef CFG_READBACK_EN
    rd_expect("shadow_scale_ch0", 8'h81, 32'h9);
`else
    rd_expect("shadow_scale_ch0", 8'h81, 32'h0);
`endif
    rd_expect("active_scale_ch0_staged", 8'h41, 32'h0);
    gpio_write(16'h0018, 8'h03, 6);
    do_commit("commit3");
    chk("scale_out_after_commit", {56'h0, scale_out}, 64'h09);
    chk("sinc_after_commit", {62'h0, sinc_out}, 64'h1);
    chk("ucntr_after_commit", {62'h0, ucntr_out}, 64'h1);
    rd_expect("active_ctrl_ch0", 8'h42, 32'h3);

    // Reset mid-write, strobe still high at release
    @(negedge clk);
    gpio_in = {8'h00, 8'h3C, 16'h0000};
    repeat (2) @(negedge clk);
    gpio_in[24] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    repeat (3) @(negedge clk);
    chk("midrst_led", {56'h0, led_out}, 64'h0);
    chk("midrst_inc", inc_out, 64'h0);
    chk("midrst_gpio_out", {32'h0, gpio_out}, 64'h0);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("strobe_high_at_release_led", {56'h0, led_out}, 64'h0);
    chk("strobe_high_at_release_id", {32'h0, gpio_out}, 64'h4C4B_0002);
    gpio_in[24] = 1'b0;
    repeat (6) @(negedge clk);
    gpio_write(16'h0008, 8'h01, 4);
    chk("cnt_after_reset", {32'h0, gpio_out}, 64'(exp_cnt));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
